// File: rtl/tone_scheduler_pkg.sv
// Shared definitions for the tone scheduler: tone codes, FSM encoding and
// the default sizing parameters.
package tone_scheduler_pkg;

  // Default request FIFO depth (power of two, at least 2).
  localparam int DEFAULT_DEPTH = 4;
  // Default width of the duration / gap counters.
  localparam int DEFAULT_CNT_W = 6;
  // Width of a tone code.
  localparam int SOUND_W = 3;

  // Tone codes understood by the speaker tone generator. Codes 6 and 7
  // are legal requests but produce a silent slot.
  typedef enum logic [SOUND_W-1:0] {
    RED    = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    BLUE   = 3'd3,
    S_WIN  = 3'd4,
    S_LOSS = 3'd5
  } tone_code_e;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // A code drives the speaker only if it names a real tone.
  function automatic logic is_audible(input logic [SOUND_W-1:0] code);
    return code <= SOUND_W'(S_LOSS);
  endfunction

endpackage

// File: rtl/tone_fifo.sv
// Request FIFO for the tone scheduler. Show-ahead: the head entry is
// visible on rd_data while the FIFO is non-empty, so the FSM can load it
// in the same cycle it pops. Flush clears pointers and count and wins over
// any simultaneous push or pop.
module tone_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rd_data = mem_q[rd_ptr_q];

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tone_scheduler.sv
// Tone scheduler: queues {sound, dur, gap} requests and plays them one
// after another, driving play/sound for the speaker tone generator. Each
// request gives dur+1 tone cycles followed by gap+1 silent cycles, with a
// one-cycle done pulse registered at the end of the gap.
module tone_scheduler #(
  parameter int DEPTH = tone_scheduler_pkg::DEFAULT_DEPTH,
  parameter int CNT_W = tone_scheduler_pkg::DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sound,
  input  logic [CNT_W-1:0] req_dur,
  input  logic [CNT_W-1:0] req_gap,
  input  logic             flush,
  output logic             play,
  output logic [2:0]       sound,
  output logic             busy,
  output logic             done
);

  import tone_scheduler_pkg::*;

  localparam int ENTRY_W = SOUND_W + 2 * CNT_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic               play_q, play_d;
  logic [SOUND_W-1:0] sound_q, sound_d;
  logic               done_q, done_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic [SOUND_W-1:0] head_sound;
  logic [CNT_W-1:0]   head_dur;
  logic [CNT_W-1:0]   head_gap;
  logic               launch;

  // A pop in the same cycle never frees a slot for a push: readiness looks
  // only at the registered full flag.
  assign req_ready    = ~fifo_full & ~flush;
  assign fifo_push    = req_valid & req_ready;
  assign fifo_wr_data = {req_sound, req_dur, req_gap};
  assign {head_sound, head_dur, head_gap} = fifo_rd_data;

  tone_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM next-state: count down the tone, then the gap; launch the next
  // queued request from IDLE or straight out of a finished gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    play_d   = play_q;
    sound_d  = sound_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    launch   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      play_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          launch = ~fifo_empty;
        end
        ST_TONE: begin
          if (cnt_q == '0) begin
            play_d  = 1'b0;
            cnt_d   = gap_q;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            launch  = ~fifo_empty;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          play_d  = 1'b0;
        end
      endcase
      // Start the head request: silent codes keep play low but still
      // show their code on sound and use normal timing.
      if (launch) begin
        fifo_pop = 1'b1;
        cnt_d    = head_dur;
        gap_d    = head_gap;
        sound_d  = head_sound;
        play_d   = is_audible(head_sound);
        state_d  = ST_TONE;
      end
    end
  end

  // FSM, counter and output registers; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      play_q  <= 1'b0;
      sound_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      play_q  <= play_d;
      sound_q <= sound_d;
      done_q  <= done_d;
    end
  end

  assign play  = play_q;
  assign sound = sound_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE) | ~fifo_empty;

endmodule
